ej32_au_stk: RTL and testbench

- Parametrised successor to the eJ32 arithmetic unit: a data stack (TOS register plus NOS/deeper entries in a register-file array) and an ALU.
- Generalised in data width and stack depth.
- Adds an issue handshake, stack overflow/underflow guards with sticky error flags, and a signed iterative divider with Java semantics.
- Sits under the eJ32 control FSM, which decodes bytecodes into the compact op set below.

---
 rtl/ej32_au_stk.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_ej32_au_stk.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ej32_au_stk.sv
// ej32_au_stk: eJ32 arithmetic unit with a parametrised data stack and ALU.
// TOS lives in t_q, NOS and deeper items in a register array; s_q shadows
// the top array entry so NOS is available without an array read.
// Optional macro AU_DIV_EN builds the iterative signed divider (DIV/REM);
// without it DIV/REM finish in one cycle with a zero result and dz_o set.
module ej32_au_stk #(
  parameter int DSZ   = 32,
  parameter int DEPTH = 16,
  parameter int DPW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           op_vld,
  output logic           op_rdy,
  input  logic [3:0]     op,
  input  logic [DSZ-1:0] d_i,
  output logic [DSZ-1:0] t_o,
  output logic [DSZ-1:0] s_o,
  output logic [DPW-1:0] depth_o,
  output logic           busy_o,
  input  logic           err_clr,
  output logic           ovf_o,
  output logic           unf_o,
  output logic           dz_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(DSZ);
  localparam logic [DPW-1:0] FULL = DPW'(DEPTH);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_DUP  = 4'd3;
  localparam logic [3:0] OP_SWAP = 4'd4;
  localparam logic [3:0] OP_OVER = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_XOR  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;
  localparam logic [3:0] OP_USHR = 4'd13;
  localparam logic [3:0] OP_DIV  = 4'd14;
  localparam logic [3:0] OP_REM  = 4'd15;

  // Two's-complement magnitude; MIN maps onto itself, which is correct as unsigned.
  function automatic logic [DSZ-1:0] abs_f(input logic [DSZ-1:0] v);
    abs_f = v[DSZ-1] ? (~v + DSZ'(1)) : v;
  endfunction

  logic [DSZ-1:0] t_q, s_q;
  logic [DPW-1:0] depth_q;
  logic           ovf_q, unf_q, dz_q;
  logic [DSZ-1:0] mem [DEPTH];

  logic [DSZ-1:0] t_d, s_d;
  logic [DPW-1:0] depth_d;
  logic           wr_en_s;
  logic [AW-1:0]  wr_idx_s;
  logic [DSZ-1:0] wr_dat_s;
  logic           set_ovf_s, set_unf_s, set_dz_s, start_div_s;
  logic           acc_s, full_s, empty_s, lt2_s;
  logic [DPW-1:0] dm1_s, dm2_s, dm3_s;
  logic [DSZ-1:0] pop_s, alu_s;
  logic [SW-1:0]  shamt_s;

  assign acc_s   = op_vld & op_rdy;
  assign full_s  = (depth_q == FULL);
  assign empty_s = (depth_q == DPW'(0));
  assign lt2_s   = (depth_q < DPW'(2));
  assign dm1_s   = depth_q - DPW'(1);
  assign dm2_s   = depth_q - DPW'(2);
  assign dm3_s   = depth_q - DPW'(3);
  assign pop_s   = (depth_q >= DPW'(3)) ? mem[dm3_s[AW-1:0]] : '0;
  assign shamt_s = t_q[SW-1:0];

`ifdef AU_DIV_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} st_e;
  st_e            st_q;
  logic           busy_q;
  logic [SW-1:0]  cnt_q;
  logic [DSZ-1:0] quo_q, rem_q, dvs_q;
  logic           sa_q, qneg_q, zdiv_q, remop_q;
  logic [DSZ:0]   r_sh_s;
  logic [DSZ-1:0] r_sub_s, r_nx_s, q_fin_s, r_fin_s, div_res_s;
  logic           q_bit_s;

  // One restoring-division step plus final sign correction of the result.
  always_comb begin
    r_sh_s  = {rem_q, quo_q[DSZ-1]};
    r_sub_s = r_sh_s[DSZ-1:0] - dvs_q;
    q_bit_s = (r_sh_s >= {1'b0, dvs_q});
    if (q_bit_s) begin
      r_nx_s = r_sub_s;
    end else begin
      r_nx_s = r_sh_s[DSZ-1:0];
    end
    if (zdiv_q) begin
      q_fin_s = '1;
    end else if (qneg_q) begin
      q_fin_s = ~quo_q + DSZ'(1);
    end else begin
      q_fin_s = quo_q;
    end
    r_fin_s   = sa_q ? (~rem_q + DSZ'(1)) : rem_q;
    div_res_s = remop_q ? r_fin_s : q_fin_s;
  end

  assign busy_o = busy_q;
  assign op_rdy = ~busy_q;
`else
  assign busy_o = 1'b0;
  assign op_rdy = 1'b1;
`endif

  assign t_o     = t_q;
  assign s_o     = s_q;
  assign depth_o = depth_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;
  assign dz_o    = dz_q;

  // Binary ALU: result is NOS op TOS.
  always_comb begin
    case (op)
      OP_ADD:  alu_s = s_q + t_q;
      OP_SUB:  alu_s = s_q - t_q;
      OP_AND:  alu_s = s_q & t_q;
      OP_OR:   alu_s = s_q | t_q;
      OP_XOR:  alu_s = s_q ^ t_q;
      OP_SHL:  alu_s = s_q << shamt_s;
      OP_SHR:  alu_s = DSZ'($signed(s_q) >>> shamt_s);
      OP_USHR: alu_s = s_q >> shamt_s;
      default: alu_s = '0;
    endcase
  end

  // Stack next-state: op decode, guard checks and array write port.
  always_comb begin
    t_d         = t_q;
    s_d         = s_q;
    depth_d     = depth_q;
    wr_en_s     = 1'b0;
    wr_idx_s    = dm1_s[AW-1:0];
    wr_dat_s    = t_q;
    set_ovf_s   = 1'b0;
    set_unf_s   = 1'b0;
    set_dz_s    = 1'b0;
    start_div_s = 1'b0;
`ifdef AU_DIV_EN
    if (st_q == ST_DONE) begin
      t_d     = div_res_s;
      s_d     = pop_s;
      depth_d = dm1_s;
    end else
`endif
    if (acc_s) begin
      case (op)
        OP_NOP: begin
          t_d = t_q;
        end
        OP_PUSH: begin
          if (full_s) begin
            set_ovf_s = 1'b1;
          end else begin
            t_d     = d_i;
            depth_d = depth_q + DPW'(1);
            if (!empty_s) begin
              s_d     = t_q;
              wr_en_s = 1'b1;
            end else begin
              s_d = s_q;
            end
          end
        end
        OP_POP: begin
          if (empty_s) begin
            set_unf_s = 1'b1;
          end else begin
            t_d     = s_q;
            s_d     = pop_s;
            depth_d = dm1_s;
          end
        end
        OP_DUP: begin
          if (empty_s) begin
            set_unf_s = 1'b1;
          end else if (full_s) begin
            set_ovf_s = 1'b1;
          end else begin
            s_d     = t_q;
            wr_en_s = 1'b1;
            depth_d = depth_q + DPW'(1);
          end
        end
        OP_SWAP: begin
          if (lt2_s) begin
            set_unf_s = 1'b1;
          end else begin
            t_d      = s_q;
            s_d      = t_q;
            wr_en_s  = 1'b1;
            wr_idx_s = dm2_s[AW-1:0];
          end
        end
        OP_OVER: begin
          if (lt2_s) begin
            set_unf_s = 1'b1;
          end else if (full_s) begin
            set_ovf_s = 1'b1;
          end else begin
            t_d     = s_q;
            s_d     = t_q;
            wr_en_s = 1'b1;
            depth_d = depth_q + DPW'(1);
          end
        end
        OP_DIV, OP_REM: begin
          if (lt2_s) begin
            set_unf_s = 1'b1;
          end else begin
`ifdef AU_DIV_EN
            start_div_s = 1'b1;
            set_dz_s    = (t_q == '0);
`else
            t_d      = '0;
            s_d      = pop_s;
            depth_d  = dm1_s;
            set_dz_s = 1'b1;
`endif
          end
        end
        default: begin
          if (lt2_s) begin
            set_unf_s = 1'b1;
          end else begin
            t_d     = alu_s;
            s_d     = pop_s;
            depth_d = dm1_s;
          end
        end
      endcase
    end else begin
      t_d = t_q;
    end
  end

  // Array storage for NOS and deeper items; contents need no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_idx_s] <= wr_dat_s;
    end
  end

  // Stack registers, sticky flags (set beats clear) and divider FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_q     <= '0;
      s_q     <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      dz_q    <= 1'b0;
`ifdef AU_DIV_EN
      st_q    <= ST_IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      sa_q    <= 1'b0;
      qneg_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      remop_q <= 1'b0;
`endif
    end else begin
      t_q     <= t_d;
      s_q     <= s_d;
      depth_q <= depth_d;
      ovf_q   <= set_ovf_s | (ovf_q & ~err_clr);
      unf_q   <= set_unf_s | (unf_q & ~err_clr);
      dz_q    <= set_dz_s  | (dz_q  & ~err_clr);
`ifdef AU_DIV_EN
      case (st_q)
        ST_IDLE: begin
          if (start_div_s) begin
            st_q    <= ST_BUSY;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            quo_q   <= abs_f(s_q);
            rem_q   <= '0;
            dvs_q   <= abs_f(t_q);
            sa_q    <= s_q[DSZ-1];
            qneg_q  <= s_q[DSZ-1] ^ t_q[DSZ-1];
            zdiv_q  <= (t_q == '0);
            remop_q <= (op == OP_REM);
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_BUSY: begin
          quo_q <= {quo_q[DSZ-2:0], q_bit_s};
          rem_q <= r_nx_s;
          cnt_q <= cnt_q + SW'(1);
          if (cnt_q == SW'(DSZ - 1)) begin
            st_q <= ST_DONE;
          end else begin
            st_q <= ST_BUSY;
          end
        end
        ST_DONE: begin
          st_q   <= ST_IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          st_q   <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
`endif
    end
  end

endmodule

// File: tb/tb_ej32_au_stk.sv
// Directed self-checking bench for ej32_au_stk (DSZ=32, DEPTH=16).
module tb_ej32_au_stk;

  localparam logic [3:0] NOP = 4'd0, PUSH = 4'd1, POP = 4'd2, DUP = 4'd3;
  localparam logic [3:0] SWAP = 4'd4, OVER = 4'd5, ADD = 4'd6, SUB = 4'd7;
  localparam logic [3:0] AND_ = 4'd8, OR_ = 4'd9, XOR_ = 4'd10, SHL = 4'd11;
  localparam logic [3:0] SHR = 4'd12, USHR = 4'd13, DIV = 4'd14, REM = 4'd15;

  logic        clk, rst_n, op_vld, op_rdy, busy_o, err_clr, ovf_o, unf_o, dz_o;
  logic [3:0]  op;
  logic [31:0] d_i, t_o, s_o;
  logic [4:0]  depth_o;
  int checks = 0;
  int failures = 0;

  ej32_au_stk #(.DSZ(32), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .op_vld(op_vld), .op_rdy(op_rdy), .op(op),
    .d_i(d_i), .t_o(t_o), .s_o(s_o), .depth_o(depth_o), .busy_o(busy_o),
    .err_clr(err_clr), .ovf_o(ovf_o), .unf_o(unf_o), .dz_o(dz_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    op_vld = 1'b0; op = NOP; d_i = 32'd0; err_clr = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] d);
    op_vld = 1'b1; op = o; d_i = d;
    @(posedge clk); #1;
    op_vld = 1'b0; op = NOP; d_i = 32'd0;
  endtask

  // Issue DIV/REM and measure how many sampled cycles op_rdy stays low.
  task automatic issue_div(input logic [3:0] o, output int lat);
    issue(o, 32'd0);
    lat = 0;
    while (op_rdy !== 1'b1 && lat < 100) begin
      lat++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (t_o !== 32'd0) begin failures++; $display("FAIL reset_t got=%h exp=0", t_o); end
    checks++; if (s_o !== 32'd0) begin failures++; $display("FAIL reset_s got=%h exp=0", s_o); end
    checks++; if (depth_o !== 5'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth_o); end
    checks++; if ({busy_o, op_rdy} !== 2'b01) begin failures++; $display("FAIL reset_hs got=%b exp=01", {busy_o, op_rdy}); end
    checks++; if ({ovf_o, unf_o, dz_o} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {ovf_o, unf_o, dz_o}); end
  endtask

  task automatic test_add();
    do_reset();
    issue(PUSH, 32'd5);
    checks++; if (s_o !== 32'd0 || depth_o !== 5'd1) begin failures++; $display("FAIL push1 s=%h depth=%0d exp s=0 depth=1", s_o, depth_o); end
    issue(PUSH, 32'd7);
    checks++; if (t_o !== 32'd7 || s_o !== 32'd5 || depth_o !== 5'd2) begin failures++; $display("FAIL push2 t=%h s=%h depth=%0d exp 7 5 2", t_o, s_o, depth_o); end
    issue(ADD, 32'd0);
    checks++; if (t_o !== 32'd12) begin failures++; $display("FAIL add_t got=%h exp=0000000c", t_o); end
    checks++; if (depth_o !== 5'd1 || s_o !== 32'd0) begin failures++; $display("FAIL add_ds depth=%0d s=%h exp 1 0", depth_o, s_o); end
    checks++; if ({ovf_o, unf_o, dz_o} !== 3'b000) begin failures++; $display("FAIL add_flags got=%b exp=000", {ovf_o, unf_o, dz_o}); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 16; i++) issue(PUSH, 32'(i));
    checks++; if (depth_o !== 5'd16 || t_o !== 32'd16 || s_o !== 32'd15) begin failures++; $display("FAIL fill depth=%0d t=%h s=%h exp 16 16 15", depth_o, t_o, s_o); end
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL fill_ovf got=%b exp=0", ovf_o); end
    issue(PUSH, 32'd99);
    checks++; if (depth_o !== 5'd16 || t_o !== 32'd16 || s_o !== 32'd15) begin failures++; $display("FAIL ovf_stack depth=%0d t=%h s=%h exp 16 16 15", depth_o, t_o, s_o); end
    checks++; if (ovf_o !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", ovf_o); end
    issue(DUP, 32'd0);
    checks++; if (depth_o !== 5'd16 || ovf_o !== 1'b1) begin failures++; $display("FAIL dup_full depth=%0d ovf=%b exp 16 1", depth_o, ovf_o); end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    checks++; if (ovf_o !== 1'b0) begin failures++; $display("FAIL ovf_clr got=%b exp=0", ovf_o); end
    for (int k = 1; k <= 15; k++) begin
      issue(POP, 32'd0);
      checks++;
      if (t_o !== 32'(16 - k) || s_o !== ((k < 15) ? 32'(15 - k) : 32'd0) || depth_o !== 5'(16 - k)) begin
        failures++; $display("FAIL pop_%0d t=%h s=%h depth=%0d exp t=%0d", k, t_o, s_o, depth_o, 16 - k);
      end
    end
  endtask

  task automatic test_underflow();
    do_reset();
    issue(POP, 32'd0);
    checks++; if (unf_o !== 1'b1 || depth_o !== 5'd0) begin failures++; $display("FAIL unf_pop unf=%b depth=%0d exp 1 0", unf_o, depth_o); end
    issue(PUSH, 32'd3);
    err_clr = 1'b1;
    issue(SWAP, 32'd0);
    err_clr = 1'b0;
    checks++; if (unf_o !== 1'b1 || t_o !== 32'd3 || depth_o !== 5'd1) begin failures++; $display("FAIL unf_swap unf=%b t=%h depth=%0d exp 1 3 1", unf_o, t_o, depth_o); end
    issue(ADD, 32'd0);
    checks++; if (t_o !== 32'd3 || depth_o !== 5'd1) begin failures++; $display("FAIL unf_add t=%h depth=%0d exp 3 1", t_o, depth_o); end
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
    checks++; if (unf_o !== 1'b0) begin failures++; $display("FAIL unf_clr got=%b exp=0", unf_o); end
    issue(OVER, 32'd0);
    checks++; if (unf_o !== 1'b1 || depth_o !== 5'd1) begin failures++; $display("FAIL unf_over unf=%b depth=%0d exp 1 1", unf_o, depth_o); end
  endtask

  task automatic test_stack_ops();
    do_reset();
    issue(PUSH, 32'd1); issue(PUSH, 32'd2); issue(OVER, 32'd0);
    checks++; if (t_o !== 32'd1 || s_o !== 32'd2 || depth_o !== 5'd3) begin failures++; $display("FAIL over t=%h s=%h depth=%0d exp 1 2 3", t_o, s_o, depth_o); end
    issue(DUP, 32'd0);
    checks++; if (t_o !== 32'd1 || s_o !== 32'd1 || depth_o !== 5'd4) begin failures++; $display("FAIL dup t=%h s=%h depth=%0d exp 1 1 4", t_o, s_o, depth_o); end
    issue(POP, 32'd0);
    checks++; if (t_o !== 32'd1 || s_o !== 32'd2) begin failures++; $display("FAIL pop_a t=%h s=%h exp 1 2", t_o, s_o); end
    issue(POP, 32'd0);
    checks++; if (t_o !== 32'd2 || s_o !== 32'd1) begin failures++; $display("FAIL pop_b t=%h s=%h exp 2 1", t_o, s_o); end
    issue(SWAP, 32'd0);
    checks++; if (t_o !== 32'd1 || s_o !== 32'd2 || depth_o !== 5'd2) begin failures++; $display("FAIL swap t=%h s=%h depth=%0d exp 1 2 2", t_o, s_o, depth_o); end
    issue(SUB, 32'd0);
    checks++; if (t_o !== 32'd1) begin failures++; $display("FAIL swap_sub got=%h exp=1", t_o); end
  endtask

  task automatic test_logic();
    do_reset();
    issue(PUSH, 32'd3); issue(PUSH, 32'd10); issue(SUB, 32'd0);
    checks++; if (t_o !== 32'hFFFF_FFF9) begin failures++; $display("FAIL sub got=%h exp=fffffff9", t_o); end
    issue(PUSH, 32'h0000_0F0F); issue(OR_, 32'd0);
    checks++; if (t_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL or got=%h exp=ffffffff", t_o); end
    issue(PUSH, 32'h0000_00FF); issue(XOR_, 32'd0);
    checks++; if (t_o !== 32'hFFFF_FF00) begin failures++; $display("FAIL xor got=%h exp=ffffff00", t_o); end
    issue(PUSH, 32'h0000_0FF0); issue(AND_, 32'd0);
    checks++; if (t_o !== 32'h0000_0F00) begin failures++; $display("FAIL and got=%h exp=00000f00", t_o); end
    issue(PUSH, 32'd4); issue(SHL, 32'd0);
    checks++; if (t_o !== 32'h0000_F000 || depth_o !== 5'd1) begin failures++; $display("FAIL shl t=%h depth=%0d exp 0000f000 1", t_o, depth_o); end
    issue(PUSH, 32'hFFFF_FFFF); issue(ADD, 32'd0);
    checks++; if (t_o !== 32'h0000_EFFF) begin failures++; $display("FAIL add_wrap got=%h exp=0000efff", t_o); end
  endtask

  task automatic test_shift();
    do_reset();
    issue(PUSH, 32'hF000_0000); issue(PUSH, 32'd4); issue(SHR, 32'd0);
    checks++; if (t_o !== 32'hFF00_0000) begin failures++; $display("FAIL shr got=%h exp=ff000000", t_o); end
    issue(POP, 32'd0);
    issue(PUSH, 32'hF000_0000); issue(PUSH, 32'd4); issue(USHR, 32'd0);
    checks++; if (t_o !== 32'h0F00_0000) begin failures++; $display("FAIL ushr got=%h exp=0f000000", t_o); end
    issue(PUSH, 32'd33); issue(SHL, 32'd0);
    checks++; if (t_o !== 32'h1E00_0000) begin failures++; $display("FAIL shl_mask got=%h exp=1e000000", t_o); end
  endtask

  task automatic div_case(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_t, input string nm);
    int lat;
    do_reset();
    issue(PUSH, a); issue(PUSH, b);
    issue_div(o, lat);
`ifdef AU_DIV_EN
    checks++; if (lat !== 33) begin failures++; $display("FAIL %s_lat got=%0d exp=33", nm, lat); end
`else
    checks++; if (lat !== 0 || busy_o !== 1'b0) begin failures++; $display("FAIL %s_lat got=%0d busy=%b exp 0 0", nm, lat, busy_o); end
`endif
    checks++; if (t_o !== exp_t || depth_o !== 5'd1) begin failures++; $display("FAIL %s t=%h depth=%0d exp %h 1", nm, t_o, depth_o, exp_t); end
  endtask

  task automatic test_div();
    int lat;
`ifdef AU_DIV_EN
    div_case(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    checks++; if (dz_o !== 1'b0) begin failures++; $display("FAIL div_nodz got=%b exp=0", dz_o); end
    div_case(REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    div_case(DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
    div_case(REM, 32'd7, 32'hFFFF_FFFE, 32'd1, "rem_7_m2");
    div_case(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_min");
    div_case(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_min");
    div_case(DIV, 32'd9, 32'd0, 32'hFFFF_FFFF, "div_zero");
    checks++; if (dz_o !== 1'b1) begin failures++; $display("FAIL div_zero_dz got=%b exp=1", dz_o); end
    div_case(REM, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, "rem_zero");
`else
    div_case(DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, "div_off");
    checks++; if (dz_o !== 1'b1) begin failures++; $display("FAIL div_off_dz got=%b exp=1", dz_o); end
    div_case(REM, 32'd9, 32'd0, 32'd0, "rem_off");
`endif
    do_reset();
    issue(PUSH, 32'd9);
    issue_div(DIV, lat);
    checks++; if (lat !== 0 || unf_o !== 1'b1 || dz_o !== 1'b0 || t_o !== 32'd9) begin failures++; $display("FAIL div_unf lat=%0d unf=%b dz=%b t=%h exp 0 1 0 9", lat, unf_o, dz_o, t_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue(PUSH, 32'hFFFF_FFF9); issue(PUSH, 32'd2); issue(PUSH, 32'd0);
    issue(DIV, 32'd0);
    repeat (5) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    checks++; if (t_o !== 32'd0 || s_o !== 32'd0 || depth_o !== 5'd0) begin failures++; $display("FAIL rstmid_stack t=%h s=%h depth=%0d exp 0 0 0", t_o, s_o, depth_o); end
    checks++; if ({busy_o, op_rdy, ovf_o, unf_o, dz_o} !== 5'b01000) begin failures++; $display("FAIL rstmid_ctl got=%b exp=01000", {busy_o, op_rdy, ovf_o, unf_o, dz_o}); end
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (t_o !== 32'd0 || depth_o !== 5'd0 || busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_nowb t=%h depth=%0d busy=%b exp 0 0 0", t_o, depth_o, busy_o); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    op_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = PUSH; d_i = 32'(10 * (i + 1));
      @(posedge clk); #1;
    end
    op = ADD; @(posedge clk); #1;
    op = ADD; @(posedge clk); #1;
    op_vld = 1'b0; op = NOP;
    checks++; if (t_o !== 32'd90 || s_o !== 32'd10 || depth_o !== 5'd2) begin failures++; $display("FAIL b2b t=%0d s=%0d depth=%0d exp 90 10 2", t_o, s_o, depth_o); end
    issue(NOP, 32'd0);
    checks++; if (t_o !== 32'd90 || depth_o !== 5'd2) begin failures++; $display("FAIL nop t=%0d depth=%0d exp 90 2", t_o, depth_o); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; op_vld = 1'b0; op = NOP; d_i = 32'd0; err_clr = 1'b0;
    test_reset();
    test_add();
    test_overflow();
    test_underflow();
    test_stack_ops();
    test_logic();
    test_shift();
    test_div();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
